// File: rtl/encoder_pkg.sv
// Shared defaults and FSM state encodings for the pulse-interval encoder.
// The matching decoder takes its interval timing from these same constants.
package encoder_pkg;

  localparam int DEF_PACKET_SIZE   = 8;
  localparam int DEF_COUNTER_SIZE  = 4;
  localparam int DEF_INTERVAL_LOW  = 2;
  localparam int DEF_INTERVAL_HIGH = 4;
  localparam int DEF_GUARD_CYCLES  = DEF_INTERVAL_HIGH;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_START_PULSE = 3'd1;
  localparam logic [2:0] ST_GAP         = 3'd2;
  localparam logic [2:0] ST_DATA_PULSE  = 3'd3;
  localparam logic [2:0] ST_GUARD       = 3'd4;

endpackage

// File: rtl/encoder.sv
// Pulse-interval encoder: a start pulse, then one pulse per data bit (LSB first),
// where the low gap before each data pulse encodes the bit value.
module encoder
  import encoder_pkg::*;
#(
  parameter int PACKET_SIZE   = DEF_PACKET_SIZE,
  parameter int COUNTER_SIZE  = DEF_COUNTER_SIZE,
  parameter int INTERVAL_LOW  = DEF_INTERVAL_LOW,
  parameter int INTERVAL_HIGH = DEF_INTERVAL_HIGH,
  parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PACKET_SIZE-1:0] data,
  input  logic                   start,
  output logic                   ready,
  output logic                   signal,
  output logic                   done
);

  if (INTERVAL_LOW < 1 || INTERVAL_HIGH < INTERVAL_LOW + 2 ||
      INTERVAL_HIGH >= 2 ** COUNTER_SIZE || GUARD_CYCLES < 1 ||
      GUARD_CYCLES >= 2 ** COUNTER_SIZE || PACKET_SIZE < 1 ||
      PACKET_SIZE > 2 ** (COUNTER_SIZE + 1)) begin : g_param_error
    $error("encoder: illegal parameter combination");
  end

  // Counters restart from zero on every GAP/GUARD entry and stop at a terminal value.
  localparam logic [COUNTER_SIZE-1:0] L_LOW_TERM   = COUNTER_SIZE'(INTERVAL_LOW - 1);
  localparam logic [COUNTER_SIZE-1:0] L_HIGH_TERM  = COUNTER_SIZE'(INTERVAL_HIGH - 1);
  localparam logic [COUNTER_SIZE-1:0] L_GUARD_TERM = COUNTER_SIZE'(GUARD_CYCLES - 1);
  localparam logic [COUNTER_SIZE:0]   L_IDX_LAST   = (COUNTER_SIZE + 1)'(PACKET_SIZE - 1);

  logic [2:0]              r_state;
  logic [2:0]              w_state_next;
  logic [COUNTER_SIZE-1:0] r_cnt;
  logic [COUNTER_SIZE:0]   r_idx;
  logic [PACKET_SIZE-1:0]  r_hold;
  logic                    r_signal;
  logic                    r_done;
  logic                    r_ready;
  logic [COUNTER_SIZE-1:0] w_gap_term;
  logic                    w_gap_end;
  logic                    w_guard_end;
  logic                    w_last_bit;

  // r_hold[0] is always the bit whose gap is being timed; it shifts after each data pulse.
  assign w_gap_term  = r_hold[0] ? L_HIGH_TERM : L_LOW_TERM;
  assign w_gap_end   = (r_cnt == w_gap_term);
  assign w_guard_end = (r_cnt == L_GUARD_TERM);
  assign w_last_bit  = (r_idx == L_IDX_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:        if (start) w_state_next = ST_START_PULSE;
      ST_START_PULSE: w_state_next = ST_GAP;
      ST_GAP:         if (w_gap_end) w_state_next = ST_DATA_PULSE;
      ST_DATA_PULSE:  w_state_next = w_last_bit ? ST_GUARD : ST_GAP;
      ST_GUARD:       if (w_guard_end) w_state_next = ST_IDLE;
      default:        w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_hold   <= '0;
      r_signal <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_signal <= (w_state_next == ST_START_PULSE) || (w_state_next == ST_DATA_PULSE);
      r_done   <= (w_state_next == ST_GUARD) && (r_state != ST_GUARD);
      r_ready  <= (w_state_next == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_hold <= data;
            r_idx  <= '0;
          end
        end
        ST_START_PULSE: r_cnt <= '0;
        ST_GAP: begin
          if (!w_gap_end) r_cnt <= r_cnt + COUNTER_SIZE'(1);
        end
        ST_DATA_PULSE: begin
          r_cnt  <= '0;
          r_hold <= r_hold >> 1;
          r_idx  <= r_idx + (COUNTER_SIZE + 1)'(1);
        end
        ST_GUARD: begin
          if (!w_guard_end) r_cnt <= r_cnt + COUNTER_SIZE'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign ready  = r_ready;
  assign signal = r_signal;
  assign done   = r_done;

endmodule

// File: tb/tb_encoder.sv
// Randomized scoreboard bench for the encoder: a packet-level model predicts
// accepted packets and ready windows; a waveform monitor decodes the pulse train.
module tb_encoder;

  localparam int P = 8;
  localparam int L = 2;
  localparam int H = 4;
  localparam int G = 4;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       start;
  logic       ready;
  logic       signal;
  logic       done;

  encoder #(
    .PACKET_SIZE  (P),
    .COUNTER_SIZE (4),
    .INTERVAL_LOW (L),
    .INTERVAL_HIGH(H),
    .GUARD_CYCLES (G)
  ) dut (
    .clock (clk),
    .reset (reset),
    .data  (data),
    .start (start),
    .ready (ready),
    .signal(signal),
    .done  (done)
  );

  typedef struct {
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   busy_until = 0;
  int   rst_cyc = -1;
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles occupied by one packet from its start pulse to the last data pulse.
  function automatic int pkt_len(input logic [7:0] d);
    int n;
    n = 0;
    for (int i = 0; i < P; i++) n += (d[i] ? H : L) + 1;
    return n;
  endfunction

  // Model: at each edge decide from the driven inputs whether a packet is accepted.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        busy_until = cyc + 1;
        rst_cyc    = cyc + 1;
      end else if (start && cyc >= busy_until) begin
        exp_q.push_back('{data: data, start_cyc: cyc + 1});
        busy_until = cyc + 1 + pkt_len(data) + 1 + G;
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: decode the pulse train mid-cycle and compare against the queue.
  initial begin
    bit         in_pkt;
    int         last;
    int         nbits;
    int         exp_done;
    int         gap;
    logic [7:0] word;
    in_pkt   = 0;
    last     = 0;
    nbits    = 0;
    exp_done = -1;
    word     = '0;
    forever begin
      @(negedge clk);
      if (cyc == rst_cyc) begin
        in_pkt   = 0;
        exp_done = -1;
      end
      tests++;
      if (ready !== (cyc >= busy_until)) begin
        fails++;
        $display("FAIL ready cyc=%0d actual=%b required=%b", cyc, ready, cyc >= busy_until);
      end
      tests++;
      if (done !== (cyc == exp_done)) begin
        fails++;
        $display("FAIL done cyc=%0d actual=%b required=%b", cyc, done, cyc == exp_done);
      end
      if (!in_pkt && exp_q.size() > 0 && exp_q[0].start_cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL start_missing cyc=%0d actual=none required=pulse@%0d", cyc, exp_q[0].start_cyc);
        void'(exp_q.pop_front());
      end
      if (signal === 1'b1) begin
        if (!in_pkt) begin
          tests++;
          if (exp_q.size() == 0 || exp_q[0].start_cyc != cyc) begin
            fails++;
            $display("FAIL spurious_pulse cyc=%0d actual=1 required=0", cyc);
          end else begin
            in_pkt = 1;
            nbits  = 0;
            word   = '0;
            last   = cyc;
          end
        end else begin
          gap = cyc - last - 1;
          tests++;
          if (gap != H && gap != L) begin
            fails++;
            $display("FAIL gap cyc=%0d actual=%0d required=%0d_or_%0d", cyc, gap, L, H);
            in_pkt = 0;
            void'(exp_q.pop_front());
          end else begin
            word[nbits] = (gap == H);
            nbits++;
            last = cyc;
            if (nbits == P) begin
              tests++;
              if (word !== exp_q[0].data) begin
                fails++;
                $display("FAIL packet cyc=%0d actual=%h required=%h", cyc, word, exp_q[0].data);
              end else begin
                $display("[TB] packet %h start@%0d last@%0d ok", word, exp_q[0].start_cyc, cyc);
              end
              void'(exp_q.pop_front());
              in_pkt   = 0;
              exp_done = cyc + 1;
            end
          end
        end
      end else if (signal !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL signal_x cyc=%0d actual=%b required=0", cyc, signal);
      end else if (in_pkt && (cyc - last - 1) > H) begin
        tests++;
        fails++;
        $display("FAIL pulse_timeout cyc=%0d actual=none required=pulse_by_%0d", cyc, last + H + 1);
        in_pkt = 0;
        void'(exp_q.pop_front());
      end
    end
  end

  // One call defines the inputs for one clock cycle.
  task automatic tick(input logic st, input logic [7:0] d, input logic rst);
    @(posedge clk);
    #2;
    start = st;
    data  = d;
    reset = rst;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick(1'b0, 8'($urandom), 1'b0);
    while (cyc < busy_until && n < 200) begin
      tick(1'b0, 8'($urandom), 1'b0);
      n++;
    end
    if (cyc < busy_until) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout cyc=%0d actual=busy required=idle", cyc);
    end
    repeat (2) tick(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d, 1'b0);
    wait_idle();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);

    send(8'hA5);
    send(8'h00);
    send(8'hFF);

    // Starts at offsets 3 and 20 with new data while busy must be ignored.
    tick(1'b1, 8'hA5, 1'b0);
    for (int o = 0; o <= 25; o++) tick((o == 3 || o == 20), 8'($urandom), 1'b0);
    wait_idle();

    // Reset at offset 10 abandons the packet; then a clean one follows.
    tick(1'b1, 8'hC3, 1'b0);
    for (int o = 0; o < 10; o++) tick(1'b0, 8'($urandom), 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    repeat (6) tick(1'b0, 8'h00, 1'b0);
    send(8'h3C);

    // Start held high: second packet is accepted in the first idle cycle.
    for (int i = 0; i <= 40; i++) tick(1'b1, (i == 0) ? 8'hA5 : 8'h5A, 1'b0);
    wait_idle();

    // Reset and start together: reset wins.
    tick(1'b1, 8'h77, 1'b1);
    repeat (8) tick(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 1500; i++)
      tick(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 59) == 0));
    wait_idle();
    repeat (5) tick(1'b0, 8'h00, 1'b0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
